// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: performs loads/stores on a 256-word synchronous
// data memory and registers the instruction's results for writeback (latency 1).
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 6
`endif

module memory_access #(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int AWIDTH   = 8
) (
  input  logic                     ms_clk,
  input  logic                     ms_rst,
  input  logic                     ms_i_ce,
  input  logic                     ms_i_stall,
  input  logic [`OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [`FUNCT_WIDTH-1:0]  ms_i_funct,
  input  logic [DWIDTH-1:0]        ms_i_alu_value,
  input  logic [DWIDTH-1:0]        ms_i_data_rt,
  input  logic [4:0]               ms_i_rd_addr,
  input  logic [PC_WIDTH-1:0]      ms_i_alu_pc,
  input  logic                     ms_i_change_pc,
  output logic                     ms_o_ce,
  output logic [`OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic [`FUNCT_WIDTH-1:0]  ms_o_funct,
  output logic [DWIDTH-1:0]        ms_o_alu_value,
  output logic [DWIDTH-1:0]        ms_o_load_data,
  output logic [4:0]               ms_o_rd_addr,
  output logic [PC_WIDTH-1:0]      ms_o_alu_pc,
  output logic                     ms_o_change_pc,
  output logic                     ms_o_misaligned
);

  localparam logic [`OPCODE_WIDTH-1:0] OP_LW  = 6'b100011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LH  = 6'b100001;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LHU = 6'b100101;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LB  = 6'b100000;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LBU = 6'b100100;
  localparam logic [`OPCODE_WIDTH-1:0] OP_SW  = 6'b101011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_SH  = 6'b101001;
  localparam logic [`OPCODE_WIDTH-1:0] OP_SB  = 6'b101000;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  logic [AWIDTH-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              is_load, is_store, sext, misaligned, advance, wr_en;
  logic [1:0]        acc_size;
  logic [DWIDTH-1:0] rd_word, load_val, wr_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        wr_mask;

  logic                     ce_q, ce_d;
  logic [`OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [`FUNCT_WIDTH-1:0]  funct_q, funct_d;
  logic [DWIDTH-1:0]        alu_q, alu_d;
  logic [DWIDTH-1:0]        load_q, load_d;
  logic [4:0]               rd_q, rd_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic                     chg_q, chg_d;
  logic                     mis_q, mis_d;

  assign word_idx = ms_i_alu_value[AWIDTH+1:2];
  assign byte_off = ms_i_alu_value[1:0];
  assign advance  = ms_i_ce && !ms_i_stall;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    acc_size = SZ_WORD;
    case (ms_i_opcode)
      OP_LW:  begin is_load = 1'b1; acc_size = SZ_WORD; end
      OP_LH:  begin is_load = 1'b1; acc_size = SZ_HALF; sext = 1'b1; end
      OP_LHU: begin is_load = 1'b1; acc_size = SZ_HALF; end
      OP_LB:  begin is_load = 1'b1; acc_size = SZ_BYTE; sext = 1'b1; end
      OP_LBU: begin is_load = 1'b1; acc_size = SZ_BYTE; end
      OP_SW:  begin is_store = 1'b1; acc_size = SZ_WORD; end
      OP_SH:  begin is_store = 1'b1; acc_size = SZ_HALF; end
      OP_SB:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign misaligned = (is_load || is_store) &&
                      (((acc_size == SZ_WORD) && (byte_off != 2'b00)) ||
                       ((acc_size == SZ_HALF) && byte_off[0]));

  // Load path reads the pre-edge memory contents, so a store is visible one edge later.
  assign rd_word = mem_q[word_idx];

  always_comb begin
    case (byte_off)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    if (is_load && !misaligned) begin
      case (acc_size)
        SZ_BYTE: load_val = sext ? {{(DWIDTH-8){byte_v[7]}}, byte_v} : {{(DWIDTH-8){1'b0}}, byte_v};
        SZ_HALF: load_val = sext ? {{(DWIDTH-16){half_v[15]}}, half_v} : {{(DWIDTH-16){1'b0}}, half_v};
        default: load_val = rd_word;
      endcase
    end
  end

  always_comb begin
    wr_mask = 4'b0000;
    wr_data = {4{ms_i_data_rt[7:0]}};
    case (acc_size)
      SZ_BYTE: wr_mask = 4'b0001 << byte_off;
      SZ_HALF: begin
        wr_data = {2{ms_i_data_rt[15:0]}};
        wr_mask = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = ms_i_data_rt;
        wr_mask = 4'b1111;
      end
    endcase
  end

  assign wr_en = advance && is_store && !misaligned;

  // Memory is deliberately left untouched by reset; it only refuses writes while reset is held.
  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) begin
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    ce_d     = ce_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    alu_d    = alu_q;
    load_d   = load_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    chg_d    = chg_q;
    mis_d    = mis_q;
    if (!ms_i_stall) begin
      if (ms_i_ce) begin
        ce_d     = 1'b1;
        opcode_d = ms_i_opcode;
        funct_d  = ms_i_funct;
        alu_d    = ms_i_alu_value;
        load_d   = load_val;
        rd_d     = ms_i_rd_addr;
        pc_d     = ms_i_alu_pc;
        chg_d    = ms_i_change_pc;
        mis_d    = misaligned;
      end else begin
        ce_d  = 1'b0;
        chg_d = 1'b0;
        mis_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) begin
      ce_q     <= 1'b0;
      opcode_q <= '0;
      funct_q  <= '0;
      alu_q    <= '0;
      load_q   <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      chg_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      ce_q     <= ce_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      alu_q    <= alu_d;
      load_q   <= load_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      chg_q    <= chg_d;
      mis_q    <= mis_d;
    end
  end

  assign ms_o_ce         = ce_q;
  assign ms_o_opcode     = opcode_q;
  assign ms_o_funct      = funct_q;
  assign ms_o_alu_value  = alu_q;
  assign ms_o_load_data  = load_q;
  assign ms_o_rd_addr    = rd_q;
  assign ms_o_alu_pc     = pc_q;
  assign ms_o_change_pc  = chg_q;
  assign ms_o_misaligned = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: byte-addressed reference memory plus an expected-result queue
// that is filled as each instruction is driven and drained as its result appears.
module tb_memory_access;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_RT  = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] FN_ADD = 6'b100000;

  logic        ms_clk = 1'b0;
  logic        ms_rst = 1'b0;
  logic        ms_i_ce = 1'b0, ms_i_stall = 1'b0;
  logic [5:0]  ms_i_opcode = '0, ms_i_funct = '0;
  logic [31:0] ms_i_alu_value = '0, ms_i_data_rt = '0;
  logic [4:0]  ms_i_rd_addr = '0;
  logic [31:0] ms_i_alu_pc = '0;
  logic        ms_i_change_pc = 1'b0;
  logic        ms_o_ce;
  logic [5:0]  ms_o_opcode, ms_o_funct;
  logic [31:0] ms_o_alu_value, ms_o_load_data;
  logic [4:0]  ms_o_rd_addr;
  logic [31:0] ms_o_alu_pc;
  logic        ms_o_change_pc, ms_o_misaligned;

  memory_access dut (
    .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce), .ms_i_stall(ms_i_stall),
    .ms_i_opcode(ms_i_opcode), .ms_i_funct(ms_i_funct), .ms_i_alu_value(ms_i_alu_value),
    .ms_i_data_rt(ms_i_data_rt), .ms_i_rd_addr(ms_i_rd_addr), .ms_i_alu_pc(ms_i_alu_pc),
    .ms_i_change_pc(ms_i_change_pc), .ms_o_ce(ms_o_ce), .ms_o_opcode(ms_o_opcode),
    .ms_o_funct(ms_o_funct), .ms_o_alu_value(ms_o_alu_value), .ms_o_load_data(ms_o_load_data),
    .ms_o_rd_addr(ms_o_rd_addr), .ms_o_alu_pc(ms_o_alu_pc), .ms_o_change_pc(ms_o_change_pc),
    .ms_o_misaligned(ms_o_misaligned)
  );

  always #5 ms_clk = ~ms_clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        chg;
    logic        mis;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] mb [1024];
  int         total = 0;
  int         bad = 0;

  task automatic step();
    @(posedge ms_clk);
    #1;
  endtask

  // Drive one valid instruction and queue its expected result from the byte model.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                       input logic chg);
    exp_t x;
    int a;
    logic [15:0] h;
    a = int'(alu[9:0]);
    x.op = op; x.alu = alu; x.rd = rd; x.pc = pc; x.chg = chg; x.ld = '0; x.mis = 1'b0;
    case (op)
      OP_LW: if (a % 4 == 0) x.ld = {mb[a+3], mb[a+2], mb[a+1], mb[a]}; else x.mis = 1'b1;
      OP_LH, OP_LHU:
        if (a % 2 == 0) begin
          h = {mb[a+1], mb[a]};
          x.ld = (op == OP_LH) ? {{16{h[15]}}, h} : {16'h0, h};
        end else x.mis = 1'b1;
      OP_LB:  x.ld = {{24{mb[a][7]}}, mb[a]};
      OP_LBU: x.ld = {24'h0, mb[a]};
      OP_SW:
        if (a % 4 == 0) begin
          mb[a] = rt[7:0]; mb[a+1] = rt[15:8]; mb[a+2] = rt[23:16]; mb[a+3] = rt[31:24];
        end else x.mis = 1'b1;
      OP_SH:
        if (a % 2 == 0) begin mb[a] = rt[7:0]; mb[a+1] = rt[15:8]; end
        else x.mis = 1'b1;
      OP_SB: mb[a] = rt[7:0];
      default: ;
    endcase
    sb.push_back(x);
    ms_i_ce = 1'b1; ms_i_stall = 1'b0; ms_i_opcode = op; ms_i_funct = fn;
    ms_i_alu_value = alu; ms_i_data_rt = rt; ms_i_rd_addr = rd;
    ms_i_alu_pc = pc; ms_i_change_pc = chg;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt);
    drive(op, 6'h0, alu, rt, 5'd1, 32'h0, 1'b0);
    step();
  endtask

  task automatic pop_exp(input string tag);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s queue: got empty scoreboard, need an entry", tag);
      e = '{op: '0, alu: '0, ld: '0, rd: '0, pc: '0, chg: 1'b0, mis: 1'b0};
    end else e = sb.pop_front();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ms_o_ce, ms_o_opcode, ms_o_funct, ms_o_alu_value, ms_o_load_data, ms_o_rd_addr,
         ms_o_alu_pc, ms_o_change_pc, ms_o_misaligned} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ce=%b ld=%h alu=%h, need all zero",
               ms_o_ce, ms_o_load_data, ms_o_alu_value);
    end
    step();
    ms_rst = 1'b1;
  endtask

  task automatic test_word();
    issue(OP_SW, 32'h10, 32'h1234_5678);
    pop_exp("sw10");
    total++;
    if (ms_o_ce !== 1'b1 || ms_o_load_data !== e.ld) begin
      bad++; $display("FAIL sw10: got ce=%b ld=%h, need ce=1 ld=%h", ms_o_ce, ms_o_load_data, e.ld);
    end
    issue(OP_LW, 32'h10, 32'h0);
    pop_exp("lw10");
    total++;
    if (ms_o_ce !== 1'b1 || ms_o_load_data !== 32'h1234_5678 || ms_o_load_data !== e.ld) begin
      bad++; $display("FAIL lw10: got ce=%b ld=%h, need ce=1 ld=12345678", ms_o_ce, ms_o_load_data);
    end
  endtask

  task automatic test_byte();
    logic [31:0] need [3];
    need[0] = 32'h0000_AB00; need[1] = 32'hFFFF_FFAB; need[2] = 32'h0000_00AB;
    issue(OP_SW, 32'h0, 32'h0);
    issue(OP_SB, 32'h1, 32'h0000_00AB);
    void'(sb.pop_front()); void'(sb.pop_front());
    issue(OP_LW, 32'h0, 32'h0);
    issue(OP_LB, 32'h1, 32'h0);
    issue(OP_LBU, 32'h1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      pop_exp("byte_lane");
      total++;
      if (e.ld !== need[i]) begin
        bad++; $display("FAIL byte_model[%0d]: got %h, need %h", i, e.ld, need[i]);
      end
    end
    // last result still visible: LBU of byte 1
    total++;
    if (ms_o_load_data !== 32'h0000_00AB) begin
      bad++; $display("FAIL lbu1: got %h, need 000000ab", ms_o_load_data);
    end
    issue(OP_LB, 32'h1, 32'h0);
    pop_exp("lb1");
    total++;
    if (ms_o_load_data !== 32'hFFFF_FFAB) begin
      bad++; $display("FAIL lb1: got %h, need ffffffab", ms_o_load_data);
    end
    issue(OP_LW, 32'h0, 32'h0);
    pop_exp("lw0");
    total++;
    if (ms_o_load_data !== 32'h0000_AB00) begin
      bad++; $display("FAIL lw0_after_sb: got %h, need 0000ab00", ms_o_load_data);
    end
  endtask

  task automatic test_half_wrap();
    issue(OP_SH, 32'h2, 32'h0000_8001);
    pop_exp("sh2");
    issue(OP_LH, 32'h2, 32'h0);
    pop_exp("lh2");
    total++;
    if (ms_o_load_data !== 32'hFFFF_8001) begin
      bad++; $display("FAIL lh2: got %h, need ffff8001", ms_o_load_data);
    end
    issue(OP_LHU, 32'h2, 32'h0);
    pop_exp("lhu2");
    total++;
    if (ms_o_load_data !== 32'h0000_8001) begin
      bad++; $display("FAIL lhu2: got %h, need 00008001", ms_o_load_data);
    end
    issue(OP_LW, 32'h402, 32'h0);
    pop_exp("lw402");
    total++;
    if (ms_o_misaligned !== 1'b1 || ms_o_load_data !== 32'h0 || ms_o_alu_value !== 32'h402) begin
      bad++; $display("FAIL lw_misaligned: got mis=%b ld=%h alu=%h, need mis=1 ld=0 alu=402",
                      ms_o_misaligned, ms_o_load_data, ms_o_alu_value);
    end
    issue(OP_SW, 32'h400, 32'hCAFE_BABE);
    pop_exp("sw400");
    issue(OP_LW, 32'h0, 32'h0);
    pop_exp("lw0wrap");
    total++;
    if (ms_o_load_data !== 32'hCAFE_BABE || ms_o_misaligned !== 1'b0) begin
      bad++; $display("FAIL sw_wrap: got ld=%h mis=%b, need cafebabe mis=0",
                      ms_o_load_data, ms_o_misaligned);
    end
  endtask

  task automatic test_stall();
    issue(OP_LW, 32'h10, 32'h0);
    pop_exp("lw_pre_stall");
    ms_i_stall = 1'b1; ms_i_opcode = OP_LB; ms_i_alu_value = 32'h3; ms_i_rd_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ms_o_ce !== 1'b1 || ms_o_load_data !== e.ld || ms_o_alu_value !== e.alu ||
          ms_o_opcode !== e.op || ms_o_rd_addr !== e.rd) begin
        bad++; $display("FAIL stall_hold[%0d]: got ld=%h alu=%h op=%b, need ld=%h alu=%h op=%b",
                        i, ms_o_load_data, ms_o_alu_value, ms_o_opcode, e.ld, e.alu, e.op);
      end
    end
    ms_i_opcode = OP_SW; ms_i_alu_value = 32'h10; ms_i_data_rt = 32'hDEAD_BEEF;
    step();
    issue(OP_LW, 32'h10, 32'h0);
    pop_exp("lw_post_stall");
    total++;
    if (ms_o_load_data !== 32'h1234_5678) begin
      bad++; $display("FAIL stalled_sw: got %h, need 12345678", ms_o_load_data);
    end
  endtask

  task automatic test_passthru();
    drive(OP_RT, FN_ADD, 32'd9, 32'h55, 5'd3, 32'h0, 1'b0);
    step();
    pop_exp("add");
    total++;
    if (ms_o_alu_value !== 32'd9 || ms_o_rd_addr !== 5'd3 || ms_o_load_data !== 32'h0 ||
        ms_o_change_pc !== 1'b0 || ms_o_funct !== FN_ADD || ms_o_opcode !== OP_RT) begin
      bad++; $display("FAIL add_pass: got alu=%h rd=%0d ld=%h chg=%b fn=%b",
                      ms_o_alu_value, ms_o_rd_addr, ms_o_load_data, ms_o_change_pc, ms_o_funct);
    end
    drive(OP_BEQ, 6'h0, 32'h7, 32'h0, 5'd0, 32'd20, 1'b1);
    step();
    pop_exp("beq");
    total++;
    if (ms_o_change_pc !== 1'b1 || ms_o_alu_pc !== 32'd20 || ms_o_ce !== 1'b1) begin
      bad++; $display("FAIL beq: got chg=%b pc=%0d ce=%b, need chg=1 pc=20 ce=1",
                      ms_o_change_pc, ms_o_alu_pc, ms_o_ce);
    end
    ms_i_ce = 1'b0; ms_i_alu_value = 32'h99; ms_i_alu_pc = 32'd44; ms_i_change_pc = 1'b1;
    step();
    total++;
    if (ms_o_ce !== 1'b0 || ms_o_change_pc !== 1'b0 || ms_o_alu_pc !== 32'd20 ||
        ms_o_alu_value !== 32'h7) begin
      bad++; $display("FAIL bubble: got ce=%b chg=%b pc=%0d alu=%h, need ce=0 chg=0 pc=20 alu=7",
                      ms_o_ce, ms_o_change_pc, ms_o_alu_pc, ms_o_alu_value);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op;
    logic [31:0] alu;
    for (int w = 0; w < 8; w++) begin
      issue(OP_SW, 32'(w * 4), $urandom);
      pop_exp("init");
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_LW;  1: op = OP_LH;  2: op = OP_LHU; 3: op = OP_LB;
        4: op = OP_LBU; 5: op = OP_SW;  6: op = OP_SH;  7: op = OP_SB;
        default: op = OP_RT;
      endcase
      alu = 32'($urandom_range(0, 31)) | (32'($urandom_range(0, 3)) << 10);
      drive(op, 6'h0, alu, $urandom, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      step();
      pop_exp("b2b");
      total++;
      if (ms_o_ce !== 1'b1 || ms_o_load_data !== e.ld || ms_o_misaligned !== e.mis ||
          ms_o_alu_value !== e.alu || ms_o_rd_addr !== e.rd || ms_o_alu_pc !== e.pc ||
          ms_o_change_pc !== e.chg || ms_o_opcode !== e.op) begin
        bad++; $display("FAIL b2b[%0d] op=%b addr=%h: got ld=%h mis=%b, need ld=%h mis=%b",
                        i, op, alu, ms_o_load_data, ms_o_misaligned, e.ld, e.mis);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] keep;
    keep = {mb[19], mb[18], mb[17], mb[16]};
    ms_i_ce = 1'b1; ms_i_stall = 1'b0; ms_i_opcode = OP_SW; ms_i_alu_value = 32'h10;
    ms_i_data_rt = ~keep;
    #2;
    ms_rst = 1'b0;
    #1;
    total++;
    if ({ms_o_ce, ms_o_opcode, ms_o_funct, ms_o_alu_value, ms_o_load_data, ms_o_rd_addr,
         ms_o_alu_pc, ms_o_change_pc, ms_o_misaligned} !== '0) begin
      bad++; $display("FAIL async_reset: got ce=%b alu=%h pc=%h, need all zero",
                      ms_o_ce, ms_o_alu_value, ms_o_alu_pc);
    end
    step();
    ms_rst = 1'b1;
    issue(OP_LW, 32'h10, 32'h0);
    pop_exp("lw_after_rst");
    total++;
    if (ms_o_load_data !== keep || ms_o_load_data !== e.ld) begin
      bad++; $display("FAIL store_in_reset: got %h, need %h", ms_o_load_data, keep);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
    test_reset();
    test_word();
    test_byte();
    test_half_wrap();
    test_stall();
    test_passthru();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
